// File: rtl/dual_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// dual_fetch_unit_if
//
// Purpose: instruction-memory read bus between the dual fetch unit and a
//          two-port combinational instruction memory.
//
// Signals:
//   imem_addr_top  fetch address of the top slot      (fetch unit -> memory)
//   imem_addr_bot  fetch address of the bottom slot   (fetch unit -> memory)
//   imem_q_top     word stored at imem_addr_top       (memory -> fetch unit)
//   imem_q_bot     word stored at imem_addr_bot       (memory -> fetch unit)
//
// Modports:
//   master  the fetch unit (drives addresses, samples data)
//   slave   the instruction memory (samples addresses, drives data)
// -----------------------------------------------------------------------------
interface dual_fetch_unit_if #(
    parameter int PC_WIDTH = 12
);
    logic [PC_WIDTH-1:0] imem_addr_top;
    logic [PC_WIDTH-1:0] imem_addr_bot;
    logic [31:0]         imem_q_top;
    logic [31:0]         imem_q_bot;

    modport master (
        output imem_addr_top,
        output imem_addr_bot,
        input  imem_q_top,
        input  imem_q_bot
    );

    modport slave (
        input  imem_addr_top,
        input  imem_addr_bot,
        output imem_q_top,
        output imem_q_bot
    );
endinterface

// File: rtl/dual_fetch_unit.sv
// -----------------------------------------------------------------------------
// dual_fetch_unit
//
// Purpose: fetch stage feeding a two-wide fetch/decode latch. Each edge the
//          unit fetches the pair {fetch_pc, fetch_pc+1} from a combinational
//          instruction memory and loads it into the latch, unless a flush,
//          freeze or partial-issue stall changes what is loaded.
//
// Edge priority (highest first):
//   recover   -> latch gets two bubbles, fetch_pc <= recover_pc, count flush
//   redirect  -> latch gets two bubbles, fetch_pc <= redirect_pc, count flush
//   hold      -> nothing changes
//   stall_bot -> unissued bottom moves to top, new bottom is word at fetch_pc
//   otherwise -> normal advance by two words
//
// Configuration:
//   DUAL_FETCH_UNIT_DUAL_ISSUE_EN defined   : two-wide behaviour as above.
//   DUAL_FETCH_UNIT_DUAL_ISSUE_EN undefined : single issue; only the top slot
//       is loaded, fetch_pc advances by one, stall_bot is ignored and the
//       bottom-slot outputs are constant 0. imem_addr_bot still shows
//       fetch_pc+1.
//
// Ports:
//   clock           single clock, rising edge
//   reset           asynchronous active-low reset
//   imem            instruction-memory bus (dual_fetch_unit_if.master)
//   hold            global freeze
//   stall_bot       decode did not issue the latched bottom instruction
//   redirect        decode taken jump / predicted branch
//   redirect_pc     decode target (low PC_WIDTH bits used)
//   recover         execute misprediction flush
//   recover_pc      corrected PC (low PC_WIDTH bits used)
//   instruction_top latched top instruction word
//   instruction_bot latched bottom instruction word
//   pc_top          zero-extended word PC of instruction_top
//   pc_bot          zero-extended word PC of instruction_bot
//   flush_count     saturating count of bubble-loading flush edges
// -----------------------------------------------------------------------------
module dual_fetch_unit #(
    parameter int PC_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,

    dual_fetch_unit_if.master     imem,

    input  logic                  hold,
    input  logic                  stall_bot,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  recover,
    input  logic [31:0]           recover_pc,

    output logic [31:0]           instruction_top,
    output logic [31:0]           instruction_bot,
    output logic [31:0]           pc_top,
    output logic [31:0]           pc_bot,
    output logic [15:0]           flush_count
);

    localparam logic [31:0]         NOP       = 32'h0;
    localparam logic [PC_WIDTH-1:0] PC_ZERO   = '0;
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_TWO    = PC_WIDTH'(2);
    localparam logic [15:0]         COUNT_MAX = 16'hFFFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_WIDTH-1:0] fetchPc;
    logic [31:0]         instrTopQ;
    logic [PC_WIDTH-1:0] pcTopQ;
    logic [15:0]         flushCountQ;

    logic [PC_WIDTH-1:0] fetchPcNxt;
    logic [31:0]         instrTopNxt;
    logic [PC_WIDTH-1:0] pcTopNxt;
    logic [15:0]         flushCountNxt;

    // All PC arithmetic is PC_WIDTH wide so it wraps modulo 2^PC_WIDTH.
    logic [PC_WIDTH-1:0] pcPlusOne;
    logic [15:0]         flushBumped;

    assign pcPlusOne   = fetchPc + PC_ONE;
    assign flushBumped = (flushCountQ == COUNT_MAX) ? COUNT_MAX : flushCountQ + 16'd1;

    assign imem.imem_addr_top = fetchPc;
    assign imem.imem_addr_bot = pcPlusOne;

`ifdef DUAL_FETCH_UNIT_DUAL_ISSUE_EN
    // -------------------------------------------------------------------------
    // Dual issue: both latch slots are live.
    // -------------------------------------------------------------------------
    logic [31:0]         instrBotQ;
    logic [PC_WIDTH-1:0] pcBotQ;
    logic [31:0]         instrBotNxt;
    logic [PC_WIDTH-1:0] pcBotNxt;
    logic                unusedInputs;

    // Upper PC bits beyond PC_WIDTH are architecturally ignored.
    assign unusedInputs = ^{redirect_pc, recover_pc};

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        fetchPcNxt    = fetchPc;
        instrTopNxt   = instrTopQ;
        pcTopNxt      = pcTopQ;
        instrBotNxt   = instrBotQ;
        pcBotNxt      = pcBotQ;
        flushCountNxt = flushCountQ;

        if (recover) begin
            instrTopNxt   = NOP;
            pcTopNxt      = PC_ZERO;
            instrBotNxt   = NOP;
            pcBotNxt      = PC_ZERO;
            fetchPcNxt    = recover_pc[PC_WIDTH-1:0];
            flushCountNxt = flushBumped;
        end else if (redirect) begin
            instrTopNxt   = NOP;
            pcTopNxt      = PC_ZERO;
            instrBotNxt   = NOP;
            pcBotNxt      = PC_ZERO;
            fetchPcNxt    = redirect_pc[PC_WIDTH-1:0];
            flushCountNxt = flushBumped;
        end else if (hold) begin
            // Frozen: defaults already keep every register.
        end else if (stall_bot) begin
            // Decode issued only the top slot: the stranded bottom moves up
            // and is re-paired with the next sequential word.
            instrTopNxt = instrBotQ;
            pcTopNxt    = pcBotQ;
            instrBotNxt = imem.imem_q_top;
            pcBotNxt    = fetchPc;
            fetchPcNxt  = pcPlusOne;
        end else begin
            instrTopNxt = imem.imem_q_top;
            pcTopNxt    = fetchPc;
            instrBotNxt = imem.imem_q_bot;
            pcBotNxt    = pcPlusOne;
            fetchPcNxt  = fetchPc + PC_TWO;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instrBotQ <= NOP;
            pcBotQ    <= PC_ZERO;
        end else begin
            instrBotQ <= instrBotNxt;
            pcBotQ    <= pcBotNxt;
        end
    end

    assign instruction_bot = instrBotQ;
    assign pc_bot          = 32'(pcBotQ);

`else
    // -------------------------------------------------------------------------
    // Single issue: only the top slot is loaded; bottom outputs are tied off.
    // -------------------------------------------------------------------------
    logic unusedInputs;

    // stall_bot and the bottom read port have no effect in this build.
    assign unusedInputs = ^{stall_bot, imem.imem_q_bot, redirect_pc, recover_pc};

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        fetchPcNxt    = fetchPc;
        instrTopNxt   = instrTopQ;
        pcTopNxt      = pcTopQ;
        flushCountNxt = flushCountQ;

        if (recover) begin
            instrTopNxt   = NOP;
            pcTopNxt      = PC_ZERO;
            fetchPcNxt    = recover_pc[PC_WIDTH-1:0];
            flushCountNxt = flushBumped;
        end else if (redirect) begin
            instrTopNxt   = NOP;
            pcTopNxt      = PC_ZERO;
            fetchPcNxt    = redirect_pc[PC_WIDTH-1:0];
            flushCountNxt = flushBumped;
        end else if (hold) begin
            // Frozen: defaults already keep every register.
        end else begin
            instrTopNxt = imem.imem_q_top;
            pcTopNxt    = fetchPc;
            fetchPcNxt  = pcPlusOne;
        end
    end

    assign instruction_bot = NOP;
    assign pc_bot          = 32'h0;
`endif

    // -------------------------------------------------------------------------
    // Shared registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetchPc     <= PC_ZERO;
            instrTopQ   <= NOP;
            pcTopQ      <= PC_ZERO;
            flushCountQ <= 16'h0;
        end else begin
            fetchPc     <= fetchPcNxt;
            instrTopQ   <= instrTopNxt;
            pcTopQ      <= pcTopNxt;
            flushCountQ <= flushCountNxt;
        end
    end

    assign instruction_top = instrTopQ;
    assign pc_top          = 32'(pcTopQ);
    assign flush_count     = flushCountQ;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_dual_fetch_unit
//
// Self-checking bench for dual_fetch_unit. A combinational memory returns
// 32'h1000 + address. A reference model computes the expected latch, fetch
// address and flush count for every edge; the expectation is queued when the
// stimulus is driven and popped and compared one time unit after the edge.
// Works in both builds (DUAL_FETCH_UNIT_DUAL_ISSUE_EN defined or not).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dual_fetch_unit;

    localparam int PW = 12;

    typedef struct {
        logic [31:0]   it;
        logic [31:0]   ib;
        logic [31:0]   pt;
        logic [31:0]   pb;
        logic [15:0]   fc;
        logic [PW-1:0] at;
        logic [PW-1:0] ab;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        hold;
    logic        stallBot;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        recover;
    logic [31:0] recoverPc;
    logic [31:0] instructionTop;
    logic [31:0] instructionBot;
    logic [31:0] pcTop;
    logic [31:0] pcBot;
    logic [15:0] flushCount;

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t sbQueue[$];

    // Reference model state
    logic [PW-1:0] mPc;
    logic [31:0]   mIt, mIb;
    logic [PW-1:0] mPt, mPb;
    logic [15:0]   mFc;

    dual_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

    assign bus.imem_q_top = 32'h1000 + 32'(bus.imem_addr_top);
    assign bus.imem_q_bot = 32'h1000 + 32'(bus.imem_addr_bot);

    dual_fetch_unit #(.PC_WIDTH(PW)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem            (bus.master),
        .hold            (hold),
        .stall_bot       (stallBot),
        .redirect        (redirect),
        .redirect_pc     (redirectPc),
        .recover         (recover),
        .recover_pc      (recoverPc),
        .instruction_top (instructionTop),
        .instruction_bot (instructionBot),
        .pc_top          (pcTop),
        .pc_bot          (pcBot),
        .flush_count     (flushCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [PW-1:0] a);
        return 32'h1000 + 32'(a);
    endfunction

    task automatic modelReset();
        mPc = '0; mIt = '0; mIb = '0; mPt = '0; mPb = '0; mFc = '0;
    endtask

    task automatic modelStep(input logic h, input logic sb, input logic rd,
                             input logic [31:0] rpc, input logic rc,
                             input logic [31:0] cpc);
        logic [PW-1:0] p1;
        p1 = mPc + PW'(1);
        if (rc || rd) begin
            mIt = '0; mIb = '0; mPt = '0; mPb = '0;
            mPc = rc ? cpc[PW-1:0] : rpc[PW-1:0];
            if (mFc != 16'hFFFF) mFc = mFc + 16'd1;
        end else if (h) begin
            // frozen
`ifdef DUAL_FETCH_UNIT_DUAL_ISSUE_EN
        end else if (sb) begin
            mIt = mIb; mPt = mPb;
            mIb = memWord(mPc); mPb = mPc;
            mPc = p1;
        end else begin
            mIt = memWord(mPc); mPt = mPc;
            mIb = memWord(p1);  mPb = p1;
            mPc = mPc + PW'(2);
        end
`else
        end else begin
            if (sb) begin end // ignored in single issue
            mIt = memWord(mPc); mPt = mPc;
            mPc = p1;
        end
`endif
    endtask

    task automatic compareOutputs(input string tag, input exp_t e);
        check({tag, ".instrTop"}, instructionTop, e.it);
        check({tag, ".instrBot"}, instructionBot, e.ib);
        check({tag, ".pcTop"},    pcTop,          e.pt);
        check({tag, ".pcBot"},    pcBot,          e.pb);
        check({tag, ".flushCnt"}, 32'(flushCount), 32'(e.fc));
        check({tag, ".addrTop"},  32'(bus.imem_addr_top), 32'(e.at));
        check({tag, ".addrBot"},  32'(bus.imem_addr_bot), 32'(e.ab));
    endtask

    // Drive one edge's inputs, queue the model's expectation, then compare
    // the DUT's post-edge state against the popped entry.
    task automatic doEdge(input string tag, input logic h, input logic sb,
                          input logic rd, input logic [31:0] rpc,
                          input logic rc, input logic [31:0] cpc);
        exp_t e;
        hold = h; stallBot = sb; redirect = rd; redirectPc = rpc;
        recover = rc; recoverPc = cpc;
        modelStep(h, sb, rd, rpc, rc, cpc);
        e.it = mIt; e.ib = mIb; e.pt = 32'(mPt); e.pb = 32'(mPb);
        e.fc = mFc; e.at = mPc; e.ab = mPc + PW'(1);
        sbQueue.push_back(e);
        @(posedge clock);
        #1;
        if (sbQueue.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            compareOutputs(tag, sbQueue.pop_front());
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".instrTop"}, instructionTop, 32'h0);
        check({tag, ".instrBot"}, instructionBot, 32'h0);
        check({tag, ".pcTop"},    pcTop,          32'h0);
        check({tag, ".pcBot"},    pcBot,          32'h0);
        check({tag, ".flushCnt"}, 32'(flushCount), 32'h0);
        check({tag, ".addrTop"},  32'(bus.imem_addr_top), 32'h0);
    endtask

    initial begin
        hold = 0; stallBot = 0; redirect = 0; redirectPc = 0;
        recover = 0; recoverPc = 0;
        reset = 1'b0;
        modelReset();
        #1;
        checkAllZero("rstAsync");
        @(posedge clock);
        #1;
        checkAllZero("rstHeld");
        reset = 1'b1;

        // Three free edges from PC 0
        for (int i = 0; i < 3; i++) doEdge("free", 0, 0, 0, 0, 0, 0);
`ifdef DUAL_FETCH_UNIT_DUAL_ISSUE_EN
        check("req032.fetchPc", 32'(bus.imem_addr_top), 32'd6);
        check("req032.top", instructionTop, 32'h1004);
        check("req032.bot", instructionBot, 32'h1005);
`else
        check("req037.fetchPc", 32'(bus.imem_addr_top), 32'd3);
        check("req037.pcTop", pcTop, 32'd2);
        check("req037.bot", instructionBot, 32'h0);
`endif

        doEdge("stallBot", 0, 1, 0, 0, 0, 0);
`ifdef DUAL_FETCH_UNIT_DUAL_ISSUE_EN
        check("req033.top", instructionTop, 32'h1005);
        check("req033.pcBot", pcBot, 32'd6);
`endif
        doEdge("redirStall", 0, 1, 1, 32'd40, 0, 0);
        check("req034.flush", 32'(flushCount), 32'd1);
        doEdge("afterRedir", 0, 0, 0, 0, 0, 0);
        check("req034.pcTop", pcTop, 32'd40);

        doEdge("recoverAll", 1, 0, 1, 32'd40, 1, 32'd9);
        check("req035.fetchPc", 32'(bus.imem_addr_top), 32'd9);
        check("req035.flush", 32'(flushCount), 32'd2);
        doEdge("afterRecover", 0, 0, 0, 0, 0, 0);

        doEdge("recoverMax", 0, 0, 0, 0, 1, 32'd4095);
        check("req024.addrBotWrap", 32'(bus.imem_addr_bot), 32'd0);
        doEdge("wrapAdvance", 0, 0, 0, 0, 0, 0);
        check("req036.pcTop", pcTop, 32'd4095);
`ifdef DUAL_FETCH_UNIT_DUAL_ISSUE_EN
        check("req036.pcBot", pcBot, 32'd0);
        check("req036.fetchPc", 32'(bus.imem_addr_top), 32'd1);
`endif

        // Hold for two edges, then drop reset between edges while held
        doEdge("hold1", 1, 0, 0, 0, 0, 0);
        doEdge("hold2", 1, 1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("rstMidHold");
        modelReset();
        @(posedge clock);
        #1;
        checkAllZero("rstMidHeld");
        reset = 1'b1;
        hold  = 1'b0;
        doEdge("postReset", 0, 0, 0, 0, 0, 0);

        // Reset asserted during a redirect cycle
        redirect = 1'b1; redirectPc = 32'd77;
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("rstMidRedir");
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        doEdge("postReset2", 0, 0, 0, 0, 0, 0);

        // Random mix of all controls
        for (int i = 0; i < 300; i++) begin
            doEdge("rand",
                   ($urandom_range(3) == 0),
                   ($urandom_range(2) == 0),
                   ($urandom_range(9) == 0),
                   $urandom,
                   ($urandom_range(15) == 0),
                   $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dual_fetch_unit.md
DUAL_FETCH_UNIT -- requirements
Module: dual_fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 12, SHALL set the instruction-memory word-address width.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_addr_top  output  PC_WIDTH  SHALL be the fetch address of the top slot (fetch_pc).
REQ-005 imem_addr_bot  output  PC_WIDTH  SHALL be the fetch address of the bottom slot (fetch_pc+1).
REQ-006 imem_q_top  input  32  SHALL be the instruction word at imem_addr_top, combinational read.
REQ-007 imem_q_bot  input  32  SHALL be the instruction word at imem_addr_bot, combinational read.
REQ-008 hold  input  1  SHALL be the global freeze (multdiv busy, downstream stall).
REQ-009 stall_bot  input  1  SHALL indicate that decode did not issue the latched bottom instruction.
REQ-010 redirect  input  1  SHALL be the decode taken-jump/predicted-branch indication.
REQ-011 redirect_pc  input  32  SHALL be the decode target; low PC_WIDTH bits used.
REQ-012 recover  input  1  SHALL be the execute misprediction flush.
REQ-013 recover_pc  input  32  SHALL be the execute-corrected PC; low PC_WIDTH bits used.
REQ-014 instruction_top, instruction_bot  output  32 each  SHALL be the fetch/decode latch instruction words.
REQ-015 pc_top, pc_bot  output  32 each  SHALL be the zero-extended word PCs of those instructions.
REQ-016 flush_count  output  16  SHALL count edges on which the latch was loaded with bubbles due to redirect or recover.

Function
REQ-017 A NOP SHALL be 32'h0; any bubble SHALL zero both the instruction word and its pc output.
REQ-018 Edge priority SHALL be: recover > redirect > hold > stall_bot > normal advance.
REQ-019 recover: latch <= two NOPs; fetch_pc <= recover_pc; flush_count increments.
REQ-020 redirect (no recover): latch <= two NOPs; fetch_pc <= redirect_pc; flush_count increments.
REQ-021 hold (no recover/redirect): latch, fetch_pc and flush_count SHALL be unchanged.
REQ-022 stall_bot: top <= old bottom (instruction and pc); bottom <= imem_q_top with pc fetch_pc; fetch_pc <= fetch_pc+1.
REQ-023 Normal advance: top <= imem_q_top/fetch_pc; bottom <= imem_q_bot/fetch_pc+1; fetch_pc <= fetch_pc+2.
REQ-024 All PC arithmetic SHALL be modulo 2^PC_WIDTH: fetch_pc = max gives imem_addr_bot = 0, and advance from max-1 gives 0.
REQ-025 flush_count SHALL saturate at 16'hFFFF.
REQ-026 Latency: an instruction at fetch_pc SHALL appear on the latch outputs one edge after fetch.

Reset
REQ-027 Reset asserted SHALL immediately force fetch_pc=0, both instructions=0, both pcs=0 and flush_count=0, regardless of the clock.
REQ-028 Reset asserted mid-operation, including during hold or redirect, SHALL discard all pending state.
REQ-029 The first rising edge after deassertion SHALL perform a normal advance from PC 0.

Configuration
REQ-030 Macro DUAL_FETCH_UNIT_DUAL_ISSUE_EN defined: behaviour SHALL be as in REQ-017..REQ-029.
REQ-031 Macro undefined (single issue):
- instruction_bot and pc_bot SHALL be constant 0.
- stall_bot SHALL be ignored.
- Normal advance SHALL load the top slot only, with fetch_pc <= fetch_pc+1.
- imem_addr_bot SHALL still equal fetch_pc+1.

Verification
REQ-032 Reset, imem word k = 32'h1000+k, 3 free edges -> latch pairs (0,1), (2,3), (4,5); fetch_pc = 6.
REQ-033 With latch at (4,5), assert stall_bot for 1 edge -> top = 32'h1005/pc 5, bot = 32'h1006/pc 6; fetch_pc = 7.
REQ-034 Assert redirect=1, redirect_pc=40 together with stall_bot -> latch = two NOPs, flush_count = 1; next edge latch = (40,41).
REQ-035 Assert recover=1, recover_pc=9 together with redirect=1, redirect_pc=40 and hold=1 -> fetch_pc = 9, flush_count increments; next edge latch = (9,10).
REQ-036 Set fetch_pc = 4095 via recover, then advance -> latch = (4095, 0); fetch_pc = 1. Drop reset mid-hold -> all outputs 0 asynchronously.
REQ-037 Build without the macro, run REQ-032 stimulus -> top pcs 0, 1, 2; bottom slot always 0.
